// File: rtl/uart_frame_rx_if.sv
// rtl/uart_frame_rx_if.sv - Command and write-data bundle between uart_frame_rx and the one-wire engine
interface uart_frame_rx_if;
  logic       cmd;
  logic       en;
  logic [6:0] adders;
  logic [7:0] num;
  logic [7:0] wdata;
  logic       wdata_rd;
  logic       wdata_vld;
  logic       busy;
  logic       err;

  modport master (
    output cmd, en, adders, num, wdata, wdata_vld, busy, err,
    input  wdata_rd
  );

  modport slave (
    input  cmd, en, adders, num, wdata, wdata_vld, busy, err,
    output wdata_rd
  );
endinterface

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - UART command-frame receiver: byte deserialiser, frame parser, CRC-16/MODBUS check, write-data FIFO
// Define UART_PARITY_EN for 8E1 characters; a parity mismatch is handled as a framing error.
module uart_frame_rx #(
  parameter int         CLK_FREQ     = 50000000,
  parameter int         BAUD         = 115200,
  parameter int         DEPTH        = 16,
  parameter logic [7:0] SOF          = 8'hAA,
  parameter logic [7:0] EOF          = 8'h55,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd,
  uart_frame_rx_if.master bus
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int BW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int TO_MAX  = TIMEOUT_BITS * BIT_CNT;
  localparam int TW      = $clog2(TO_MAX + 1);
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = $clog2(DEPTH + 1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
`ifdef UART_PARITY_EN
  localparam logic [2:0] RX_PAR   = 3'd4;
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_NUM  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CRC1 = 3'd4;
  localparam logic [2:0] S_CRC0 = 3'd5;
  localparam logic [2:0] S_EOF  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic          rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic [2:0]    rx_st_q;
  logic [BW-1:0] bcnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    rx_data_q;
  logic          rx_vld_q;
  logic          rx_ferr_q;
  logic          stop_good;
`ifdef UART_PARITY_EN
  logic          par_ok_q;
  assign stop_good = rxd_s2_q & par_ok_q;
`else
  assign stop_good = rxd_s2_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1_q  <= 1'b0;
      rxd_s2_q  <= 1'b0;
      rxd_s3_q  <= 1'b0;
      rx_st_q   <= RX_IDLE;
      bcnt_q    <= '0;
      bit_q     <= '0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_ok_q  <= 1'b0;
`endif
    end else begin
      rxd_s1_q  <= rxd;
      rxd_s2_q  <= rxd_s1_q;
      rxd_s3_q  <= rxd_s2_q;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: begin
          if (rxd_s3_q && !rxd_s2_q) begin
            rx_st_q <= RX_START;
            bcnt_q  <= '0;
          end
        end
        RX_START: begin
          // Half a bit after the edge: still low means a real start bit.
          if (bcnt_q == BW'(HALF - 1)) begin
            bcnt_q <= '0;
            bit_q  <= '0;
            rx_st_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (bcnt_q == BW'(BIT_CNT - 1)) begin
            bcnt_q    <= '0;
            rx_data_q <= {rxd_s2_q, rx_data_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_st_q <= RX_PAR;
`else
              rx_st_q <= RX_STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (bcnt_q == BW'(BIT_CNT - 1)) begin
            bcnt_q   <= '0;
            par_ok_q <= (rxd_s2_q == ^rx_data_q);
            rx_st_q  <= RX_STOP;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (bcnt_q == BW'(BIT_CNT - 1)) begin
            bcnt_q    <= '0;
            rx_st_q   <= RX_IDLE;
            rx_vld_q  <= stop_good;
            rx_ferr_q <= !stop_good;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  logic [2:0]    st_q, st_d;
  logic [TW-1:0] to_cnt_q;
  logic          cmd_l_q;
  logic [6:0]    adr_l_q;
  logic [7:0]    num_l_q;
  logic [7:0]    dcnt_q;
  logic [15:0]   crc_q;
  logic [7:0]    crc_sh_q;
  logic [3:0]    crc_cnt_q;
  logic [15:0]   crc_rx_q;
  logic          cmd_q, en_q, err_q;
  logic [6:0]    adr_q;
  logic [7:0]    num_q;
  logic          abort, push, crc_ld, sof_take, sof_ok;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          vis_q;
  logic          wdata_vld, pop;

  assign wdata_vld = vis_q && (cnt_q != '0);
  assign pop       = bus.wdata_rd && wdata_vld;
  // The last pop frees the buffer in time to accept an SOF in the same cycle.
  assign sof_ok    = !wdata_vld || (bus.wdata_rd && cnt_q == CW'(1));

  always_comb begin
    st_d     = st_q;
    abort    = 1'b0;
    push     = 1'b0;
    crc_ld   = 1'b0;
    sof_take = 1'b0;
    if (st_q == S_DONE) begin
      st_d = S_IDLE;
    end else if (st_q != S_IDLE && rx_ferr_q) begin
      abort = 1'b1;
    end else if (st_q != S_IDLE && !rx_vld_q && to_cnt_q == TW'(TO_MAX - 1)) begin
      abort = 1'b1;
    end else if (rx_vld_q) begin
      case (st_q)
        S_IDLE: begin
          if (rx_data_q == SOF && sof_ok) begin
            st_d     = S_ADDR;
            sof_take = 1'b1;
          end
        end
        S_ADDR: begin
          crc_ld = 1'b1;
          st_d   = S_NUM;
        end
        S_NUM: begin
          crc_ld = 1'b1;
          if (cmd_l_q && (32'(rx_data_q) > 32'(DEPTH))) abort = 1'b1;
          else if (cmd_l_q && rx_data_q != 8'd0)         st_d  = S_DATA;
          else                                           st_d  = S_CRC1;
        end
        S_DATA: begin
          crc_ld = 1'b1;
          push   = 1'b1;
          if (dcnt_q == num_l_q - 8'd1) st_d = S_CRC1;
        end
        S_CRC1: st_d = S_CRC0;
        S_CRC0: st_d = S_EOF;
        S_EOF: begin
          if (rx_data_q == EOF && crc_rx_q == crc_q) st_d  = S_DONE;
          else                                       abort = 1'b1;
        end
        default: st_d = S_IDLE;
      endcase
    end
    if (abort) st_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= S_IDLE;
      to_cnt_q  <= '0;
      cmd_l_q   <= 1'b0;
      adr_l_q   <= '0;
      num_l_q   <= '0;
      dcnt_q    <= '0;
      crc_q     <= '0;
      crc_sh_q  <= '0;
      crc_cnt_q <= '0;
      crc_rx_q  <= '0;
      cmd_q     <= 1'b0;
      adr_q     <= '0;
      num_q     <= '0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q  <= st_d;
      en_q  <= (st_q == S_DONE);
      err_q <= abort;
      if (st_q == S_IDLE || rx_vld_q) to_cnt_q <= '0;
      else                            to_cnt_q <= to_cnt_q + 1'b1;

      // Reflected CRC-16, one bit per clock; a byte finishes long before the next arrives.
      if (sof_take) begin
        crc_q <= 16'hFFFF;
      end else if (crc_cnt_q != 4'd0) begin
        crc_q     <= {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ crc_sh_q[0]) ? 16'hA001 : 16'h0000);
        crc_sh_q  <= {1'b0, crc_sh_q[7:1]};
        crc_cnt_q <= crc_cnt_q - 4'd1;
      end
      if (crc_ld) begin
        crc_sh_q  <= rx_data_q;
        crc_cnt_q <= 4'd8;
      end

      if (rx_vld_q && st_q == S_ADDR) {cmd_l_q, adr_l_q} <= rx_data_q;
      if (rx_vld_q && st_q == S_NUM) begin
        num_l_q <= rx_data_q;
        dcnt_q  <= '0;
      end
      if (push) dcnt_q <= dcnt_q + 8'd1;
      if (rx_vld_q && st_q == S_CRC1) crc_rx_q[15:8] <= rx_data_q;
      if (rx_vld_q && st_q == S_CRC0) crc_rx_q[7:0]  <= rx_data_q;

      if (st_q == S_DONE) begin
        cmd_q <= cmd_l_q;
        adr_q <= adr_l_q;
        num_q <= num_l_q;
      end
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vis_q <= 1'b0;
    end else if (abort) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vis_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= rx_data_q;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      // Data of a frame stays hidden until its en.
      if (st_q == S_DONE) vis_q <= 1'b1;
      else if (sof_take)  vis_q <= 1'b0;
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.en        = en_q;
  assign bus.adders    = adr_q;
  assign bus.num       = num_q;
  assign bus.err       = err_q;
  assign bus.wdata_vld = wdata_vld;
  assign bus.wdata     = wdata_vld ? mem_q[rd_q] : 8'h00;
  assign bus.busy      = (st_q != S_IDLE) || wdata_vld;

endmodule
